// File: rtl/mac_seq_if.sv
// Operand-sequencer bus: FIFO write side, run control and the MAC-facing outputs.
interface mac_seq_if;
  logic       wr_en;
  logic [7:0] wr_a;
  logic [7:0] wr_b;
  logic       start;
  logic [7:0] op_bus;
  logic       ld_a;
  logic       ld_b;
  logic       mac_go;
  logic       busy;
  logic       done;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] pairs_done;

  modport master (
    output wr_en, wr_a, wr_b, start,
    input  op_bus, ld_a, ld_b, mac_go, busy, done, full, empty, overflow, pairs_done
  );

  modport slave (
    input  wr_en, wr_a, wr_b, start,
    output op_bus, ld_a, ld_b, mac_go, busy, done, full, empty, overflow, pairs_done
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Buffers (A,B) operand pairs and replays them onto a MAC operand bus with
// the load-A / load-B / settle / long-go / gap pulse sequence.
module mac_operand_sequencer #(
  parameter int DEPTH      = 8,
  parameter int GO_CYCLES  = 20,
  parameter int GAP_CYCLES = 5
) (
  input  logic       clk,
  input  logic       btnC,
  mac_seq_if.slave   bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (GO_CYCLES > GAP_CYCLES) ? GO_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_SETTLE, S_GO, S_GAP, S_DONE
  } state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic            cnt_last;

  logic [7:0]      mem_a [DEPTH];
  logic [7:0]      mem_b [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count, count_n;
  logic            fifo_full, fifo_empty;
  logic            pop, push;

  logic [7:0]      cur_a, cur_b, cur_a_n, cur_b_n;

  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  // A pop frees a slot in the same cycle, so a write to a full FIFO is still taken.
  assign push       = bus.wr_en && (!fifo_full || pop);

  assign bus.full   = fifo_full;
  assign bus.empty  = fifo_empty;

  // GO and GAP share one dwell counter; it restarts on every state change.
  assign cnt_last = (state == S_GO) ? (cnt == CW'(GO_CYCLES - 1))
                                    : (cnt == CW'(GAP_CYCLES - 1));

  // Next-state and pop decision; a pop always coincides with entry into LOAD_A.
  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (fifo_empty) nxt = S_DONE;
          else begin
            nxt = S_LOAD_A;
            pop = 1'b1;
          end
        end
      end
      S_LOAD_A: nxt = S_LOAD_B;
      S_LOAD_B: nxt = S_SETTLE;
      S_SETTLE: nxt = S_GO;
      S_GO:     if (cnt_last) nxt = S_GAP;
      S_GAP: begin
        if (cnt_last) begin
          if (fifo_empty) nxt = S_DONE;
          else begin
            nxt = S_LOAD_A;
            pop = 1'b1;
          end
        end
      end
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + (AW+1)'(1);
      2'b01:   count_n = count - (AW+1)'(1);
      default: count_n = count;
    endcase
  end

  // Operand latch value as it will be after this edge, so outputs stay aligned with state.
  always_comb begin
    cur_a_n = cur_a;
    cur_b_n = cur_b;
    if (pop) begin
      cur_a_n = mem_a[rd_ptr];
      cur_b_n = mem_b[rd_ptr];
    end
  end

  // State register and dwell counter.
  always_ff @(posedge clk) begin
    if (btnC) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + CW'(1);
    end
  end

  // FIFO storage; contents need no reset since pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!btnC && push) begin
      mem_a[wr_ptr] <= bus.wr_a;
      mem_b[wr_ptr] <= bus.wr_b;
    end
  end

  // FIFO pointers, count, sticky overflow and the current operand latch.
  always_ff @(posedge clk) begin
    if (btnC) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      bus.overflow <= 1'b0;
      cur_a        <= '0;
      cur_b        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      if (bus.wr_en && !push) bus.overflow <= 1'b1;
      cur_a <= cur_a_n;
      cur_b <= cur_b_n;
    end
  end

  // Registered outputs decoded from the state being entered, so each strobe
  // is high exactly while the FSM sits in its state.
  always_ff @(posedge clk) begin
    if (btnC) begin
      bus.op_bus <= '0;
      bus.ld_a   <= 1'b0;
      bus.ld_b   <= 1'b0;
      bus.mac_go <= 1'b0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      bus.ld_a   <= (nxt == S_LOAD_A);
      bus.ld_b   <= (nxt == S_LOAD_B);
      bus.mac_go <= (nxt == S_GO);
      bus.done   <= (nxt == S_DONE);
      bus.busy   <= (nxt != S_IDLE);
      case (nxt)
        S_LOAD_A:          bus.op_bus <= cur_a_n;
        S_LOAD_B, S_SETTLE: bus.op_bus <= cur_b_n;
        default:           bus.op_bus <= '0;
      endcase
    end
  end

  // Pair counter: cleared by an accepted start, bumped as each GO phase ends.
  always_ff @(posedge clk) begin
    if (btnC)                          bus.pairs_done <= '0;
    else if (state == S_IDLE && bus.start) bus.pairs_done <= '0;
    else if (state == S_GO && cnt_last)    bus.pairs_done <= bus.pairs_done + 8'd1;
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: records the output trace of each run and
// compares it with the pulse sequence expanded from a queue of accepted pairs.
module tb_mac_operand_sequencer;
  localparam int DEPTH = 8;
  localparam int GO    = 20;
  localparam int GAP   = 5;

  typedef struct packed {
    logic       ld_a;
    logic       ld_b;
    logic       mac_go;
    logic       done;
    logic       busy;
    logic [7:0] op;
  } vec_t;

  logic clk = 1'b0;
  logic btnC;
  mac_seq_if bus();

  mac_operand_sequencer #(.DEPTH(DEPTH), .GO_CYCLES(GO), .GAP_CYCLES(GAP)) dut (
    .clk  (clk),
    .btnC (btnC),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mq [$];      // accepted pairs still to be issued, {a,b}
  vec_t        trace [$];
  bit          rec_en = 1'b0;

  always @(negedge clk)
    if (rec_en) trace.push_back('{bus.ld_a, bus.ld_b, bus.mac_go, bus.done, bus.busy, bus.op_bus});

  function automatic vec_t mk(logic la, logic lb, logic go, logic dn, logic bz, logic [7:0] op);
    vec_t v;
    v = '{la, lb, go, dn, bz, op};
    return v;
  endfunction

  task automatic do_reset();
    btnC = 1'b1;
    @(posedge clk); #1;
    btnC = 1'b0;
    mq.delete();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input bit acc);
    bus.wr_en = 1'b1; bus.wr_a = a; bus.wr_b = b;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    if (acc) mq.push_back({a, b});
  endtask

  task automatic begin_run();
    trace.delete();
    rec_en = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s done_timeout: done not seen, required within 2000 cycles", name);
    end
  endtask

  // Expand the model queue into the expected cycle-by-cycle output trace.
  task automatic check_run(input string name);
    vec_t exp [$];
    vec_t idle;
    int   i, shown;
    int   sum_exp, sum_got;
    logic [7:0] la, lb;
    logic prev_go;
    idle = '0;
    sum_exp = 0;
    foreach (mq[p]) begin
      exp.push_back(mk(1, 0, 0, 0, 1, mq[p][15:8]));
      exp.push_back(mk(0, 1, 0, 0, 1, mq[p][7:0]));
      exp.push_back(mk(0, 0, 0, 0, 1, mq[p][7:0]));
      for (int g = 0; g < GO; g++)  exp.push_back(mk(0, 0, 1, 0, 1, 8'h00));
      for (int g = 0; g < GAP; g++) exp.push_back(mk(0, 0, 0, 0, 1, 8'h00));
      sum_exp += int'(mq[p][15:8]) * int'(mq[p][7:0]);
    end
    exp.push_back(mk(0, 0, 0, 1, 1, 8'h00));
    i = 0;
    while (i < trace.size() && trace[i] == idle) i++;
    shown = 0;
    foreach (exp[j]) begin
      n_cmp++;
      if (i + j >= trace.size() || trace[i + j] !== exp[j]) begin
        n_err++;
        if (shown < 4)
          $display("FAIL %s trace[%0d]: got %h required %h", name, j,
                   (i + j < trace.size()) ? trace[i + j] : vec_t'('x), exp[j]);
        shown++;
      end
    end
    for (int k = i + exp.size(); k < trace.size(); k++) begin
      n_cmp++;
      if (trace[k] !== idle) begin
        n_err++;
        if (shown < 4) $display("FAIL %s tail[%0d]: got %h required %h", name, k, trace[k], idle);
        shown++;
      end
    end
    // What a downstream accumulator would total from the observed strobes.
    sum_got = 0; la = 0; lb = 0; prev_go = 0;
    foreach (trace[k]) begin
      if (trace[k].ld_a) la = trace[k].op;
      if (trace[k].ld_b) lb = trace[k].op;
      if (trace[k].mac_go && !prev_go) sum_got += int'(la) * int'(lb);
      prev_go = trace[k].mac_go;
    end
    n_cmp++;
    if (sum_got !== sum_exp) begin
      n_err++;
      $display("FAIL %s mac_sum: got %0d required %0d", name, sum_got, sum_exp);
    end
    n_cmp++;
    if (bus.pairs_done !== 8'(mq.size())) begin
      n_err++;
      $display("FAIL %s pairs_done: got %0d required %0d", name, bus.pairs_done, mq.size());
    end
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s end_state: got empty=%b busy=%b required empty=1 busy=0", name, bus.empty, bus.busy);
    end
    mq.delete();
    trace.delete();
  endtask

  task automatic end_run(input string name);
    wait_done(name);
    repeat (3) @(posedge clk);
    #1;
    rec_en = 1'b0;
    check_run(name);
  endtask

  task automatic wait_go(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.mac_go) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s go_timeout: mac_go not seen", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.op_bus, bus.ld_a, bus.ld_b, bus.mac_go, bus.busy, bus.done, bus.full,
         bus.empty, bus.overflow, bus.pairs_done} !== {8'h00, 7'b0000001, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_outputs: got op=%h la=%b lb=%b go=%b busy=%b done=%b full=%b empty=%b ovf=%b pd=%0d required all 0 except empty=1",
               bus.op_bus, bus.ld_a, bus.ld_b, bus.mac_go, bus.busy, bus.done, bus.full,
               bus.empty, bus.overflow, bus.pairs_done);
    end
  endtask

  task automatic test_basic();
    do_reset();
    push(8'd3, 8'd4, 1);
    push(8'd2, 8'd5, 1);
    begin_run();
    end_run("basic");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < DEPTH + 1; k++) begin
      push(8'($urandom), 8'($urandom), mq.size() < DEPTH);
      if (k == DEPTH - 1) begin
        n_cmp++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_full: got full=%b overflow=%b required full=1 overflow=0", bus.full, bus.overflow);
        end
      end
    end
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got full=%b overflow=%b required full=1 overflow=1", bus.full, bus.overflow);
    end
    begin_run();
    end_run("overflow_run");
    n_cmp++;
    if (bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: got overflow=%b required 1", bus.overflow);
    end
  endtask

  // Runs straight after a nonzero pairs_done, so the clear on start is exercised.
  task automatic test_empty_start(input string name);
    trace.delete();
    rec_en = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_pulse: got done=%b busy=%b required done=1 busy=1", name, bus.done, bus.busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_end: got done=%b busy=%b required done=0 busy=0", name, bus.done, bus.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    rec_en = 1'b0;
    check_run(name);
  endtask

  task automatic test_push_during_run();
    do_reset();
    push(8'($urandom), 8'($urandom), 1);
    begin_run();
    wait_go("midrun");
    push(8'd7, 8'd1, 1);
    end_run("midrun");
  endtask

  task automatic test_reset_mid_go();
    do_reset();
    for (int k = 0; k < DEPTH + 1; k++) push(8'($urandom), 8'($urandom), mq.size() < DEPTH);
    begin_run();
    wait_go("rst_go");
    repeat (9) @(posedge clk);
    #1;
    btnC = 1'b1;
    @(posedge clk); #1;
    btnC = 1'b0;
    rec_en = 1'b0;
    mq.delete();
    trace.delete();
    n_cmp++;
    if ({bus.mac_go, bus.busy, bus.empty, bus.overflow, bus.full, bus.pairs_done} !== {5'b00100, 8'h00}) begin
      n_err++;
      $display("FAIL rst_go_state: got go=%b busy=%b empty=%b ovf=%b full=%b pd=%0d required go=0 busy=0 empty=1 ovf=0 full=0 pd=0",
               bus.mac_go, bus.busy, bus.empty, bus.overflow, bus.full, bus.pairs_done);
    end
    test_empty_start("rst_go_empty");
  endtask

  task automatic test_full_pop();
    bit seen_go, fell;
    do_reset();
    for (int k = 0; k < DEPTH; k++) push(8'($urandom), 8'($urandom), 1);
    begin_run();
    push(8'($urandom), 8'($urandom), 1);
    seen_go = 0; fell = 0;
    for (int k = 0; k < 200 && !fell; k++) begin
      @(posedge clk); #1;
      if (bus.mac_go) seen_go = 1;
      else if (seen_go) fell = 1;
    end
    n_cmp++;
    if (!fell) begin
      n_err++;
      $display("FAIL fullpop_gap: GAP not reached");
    end
    repeat (GAP - 1) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.full !== 1'b1) begin
      n_err++;
      $display("FAIL fullpop_pre: got full=%b required 1", bus.full);
    end
    push(8'd9, 8'd9, 1);
    n_cmp++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fullpop_post: got full=%b overflow=%b required full=1 overflow=0", bus.full, bus.overflow);
    end
    end_run("fullpop");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n;
      do_reset();
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) push(8'($urandom), 8'($urandom), 1);
      begin_run();
      if ($urandom_range(0, 1) == 1) begin
        wait_go("random");
        push(8'($urandom), 8'($urandom), 1);
      end
      end_run("random");
    end
  endtask

  initial begin
    btnC = 1'b1;
    bus.wr_en = 1'b0; bus.wr_a = '0; bus.wr_b = '0; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_empty_start("empty_start");
    test_push_during_run();
    test_reset_mid_go();
    test_full_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
